mp_addsub_seq: RTL and testbench

MP_ADDSUB_SEQ -- requirements
Module: mp_addsub_seq

---
 rtl/mp_addsub_seq.sv | 191 +++++++++++++++++++
 tb/tb_mp_addsub_seq.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mp_addsub_seq.sv
// mp_addsub_seq
// Multi-word sequential adder/subtractor. Operands arrive one 16-bit word
// pair at a time, least-significant word first. Each result word is emitted
// before the next pair is accepted, and the carry ripples between words.
// An operation is 1 to 4 words long, giving 16- to 64-bit arithmetic.
//
// Optional feature macro: MPAS_ABORT_EN. When it is defined, an abort input
// cancels an operation that is in flight. When it is not defined, the abort
// port does not exist.
//
// Ports
//   clk          sole clock; all state changes on its rising edge
//   rst_n        asynchronous active-low reset
//   start_valid  request to begin an operation
//   start_ready  block is idle and accepts a start
//   op_sub       0 = A+B, 1 = A-B (sampled on the start handshake)
//   num_words    operand length minus one (sampled on the start handshake)
//   in_valid     a_word/b_word hold a valid operand word pair
//   in_ready     block accepts an operand word pair
//   a_word       operand A word
//   b_word       operand B word
//   out_valid    res_word holds a valid result word
//   out_ready    consumer accepts res_word
//   res_word     result word, in the same order as the inputs
//   out_last     marks the most-significant result word
//   done         one-cycle pulse when the operation completes
//   cout         final carry out
//   ovf          signed overflow of the full-width result
//   zero         every result word was zero
//   abort        synchronous cancel (only when MPAS_ABORT_EN is defined)
//
// state | meaning
// IDLE  | waiting for a start handshake; start_ready high
// LOAD  | waiting for an operand word pair; in_ready high
// EMIT  | presenting a result word; out_valid high until out_ready
// DONE  | one cycle with the done pulse, final flags valid
module mp_addsub_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_valid,
  output logic        start_ready,
  input  logic        op_sub,
  input  logic [1:0]  num_words,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a_word,
  input  logic [15:0] b_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] res_word,
  output logic        out_last,
  output logic        done,
  output logic        cout,
  output logic        ovf,
  output logic        zero
`ifdef MPAS_ABORT_EN
  ,
  input  logic        abort
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state;
  logic        op_r;
  logic [1:0]  nw_r;
  logic [1:0]  cnt;
  logic        carry;
  logic        zacc;

  logic        abort_i;
  logic [15:0] b_eff;
  logic [16:0] sum;
  logic        last_word;
  logic        ovf_word;

`ifdef MPAS_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  // Subtraction is A + ~B + 1. The +1 enters only as the first word's
  // carry-in (carry is preset to op_sub at start); later words see only
  // the carry out of the previous word.
  assign b_eff     = b_word ^ {16{op_r}};
  assign sum       = {1'b0, a_word} + {1'b0, b_eff} + {16'd0, carry};
  assign last_word = (cnt == nw_r);
  // Signed overflow is meaningful only on the most-significant word: the
  // operands agree in sign but the result does not.
  assign ovf_word  = (a_word[15] == b_eff[15]) && (sum[15] != a_word[15]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      op_r        <= 1'b0;
      nw_r        <= 2'd0;
      cnt         <= 2'd0;
      carry       <= 1'b0;
      zacc        <= 1'b0;
      start_ready <= 1'b1;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      res_word    <= 16'd0;
      done        <= 1'b0;
      cout        <= 1'b0;
      ovf         <= 1'b0;
      zero        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort_i && (state == LOAD || state == EMIT)) begin
        // Discard the operation without a done pulse. The flags are cleared
        // so that no partial result is reported.
        state       <= IDLE;
        start_ready <= 1'b1;
        in_ready    <= 1'b0;
        out_valid   <= 1'b0;
        out_last    <= 1'b0;
        cout        <= 1'b0;
        ovf         <= 1'b0;
        zero        <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start_valid) begin
              op_r        <= op_sub;
              nw_r        <= num_words;
              cnt         <= 2'd0;
              carry       <= op_sub;
              zacc        <= 1'b1;
              cout        <= 1'b0;
              ovf         <= 1'b0;
              zero        <= 1'b0;
              start_ready <= 1'b0;
              in_ready    <= 1'b1;
              state       <= LOAD;
            end
          end
          LOAD: begin
            if (in_valid) begin
              res_word  <= sum[15:0];
              carry     <= sum[16];
              zacc      <= zacc & (sum[15:0] == 16'd0);
              if (last_word) begin
                ovf <= ovf_word;
              end
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_last  <= last_word;
              state     <= EMIT;
            end
          end
          EMIT: begin
            if (out_ready) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              if (last_word) begin
                done  <= 1'b1;
                cout  <= carry;
                zero  <= zacc;
                state <= DONE;
              end else begin
                cnt      <= cnt + 2'd1;
                in_ready <= 1'b1;
                state    <= LOAD;
              end
            end
          end
          DONE: begin
            start_ready <= 1'b1;
            state       <= IDLE;
          end
          default: begin
            state       <= IDLE;
            start_ready <= 1'b1;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mp_addsub_seq.sv
module tb_mp_addsub_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start_valid = 1'b0;
  logic        start_ready;
  logic        op_sub = 1'b0;
  logic [1:0]  num_words = 2'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a_word = 16'd0;
  logic [15:0] b_word = 16'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] res_word;
  logic        out_last;
  logic        done;
  logic        cout;
  logic        ovf;
  logic        zero;
`ifdef MPAS_ABORT_EN
  logic        abort = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;

  mp_addsub_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op_sub      (op_sub),
    .num_words   (num_words),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a_word      (a_word),
    .b_word      (b_word),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .res_word    (res_word),
    .out_last    (out_last),
    .done        (done),
    .cout        (cout),
    .ovf         (ovf),
    .zero        (zero)
`ifdef MPAS_ABORT_EN
    ,
    .abort       (abort)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (done === 1'b1) done_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start_ready(input string tag);
    int k = 0;
    while (start_ready !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    check({tag, " start_ready_wait"}, 64'(start_ready), 64'd1);
  endtask

  task automatic wait_in_ready(input string tag);
    int k = 0;
    while (in_ready !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    check({tag, " in_ready_wait"}, 64'(in_ready), 64'd1);
  endtask

  task automatic do_start(input string tag, input logic op, input logic [1:0] nw);
    wait_start_ready(tag);
    op_sub      = op;
    num_words   = nw;
    start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    check({tag, " flags_cleared"}, 64'({cout, ovf, zero}), 64'd0);
  endtask

  // Full operation with no backpressure; expected values are hand-computed.
  task automatic run_op(input string tag, input logic op, input logic [1:0] nw,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp_res, input logic exp_c,
                        input logic exp_o, input logic exp_z);
    int d0;
    do_start(tag, op, nw);
    d0 = done_cnt;
    for (int i = 0; i <= int'(nw); i++) begin
      wait_in_ready(tag);
      a_word   = a[16*i +: 16];
      b_word   = b[16*i +: 16];
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      check($sformatf("%s res_word[%0d]", tag, i), 64'(res_word), 64'(exp_res[16*i +: 16]));
      check($sformatf("%s out_valid[%0d]", tag, i), 64'(out_valid), 64'd1);
      check($sformatf("%s in_ready_low[%0d]", tag, i), 64'(in_ready), 64'd0);
      check($sformatf("%s out_last[%0d]", tag, i), 64'(out_last), (i == int'(nw)) ? 64'd1 : 64'd0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
    check({tag, " done_high"}, 64'(done), 64'd1);
    check({tag, " cout"}, 64'(cout), 64'(exp_c));
    check({tag, " ovf"}, 64'(ovf), 64'(exp_o));
    check({tag, " zero"}, 64'(zero), 64'(exp_z));
    step();
    check({tag, " done_low"}, 64'(done), 64'd0);
    check({tag, " start_ready_after"}, 64'(start_ready), 64'd1);
    check({tag, " done_pulses"}, 64'(done_cnt - d0), 64'd1);
    check({tag, " flags_hold"}, 64'({cout, ovf, zero}), 64'({exp_c, exp_o, exp_z}));
  endtask

  initial begin
    int d0;
    // Reset state
    #2 rst_n = 1'b0;
    #2;
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst in_ready", 64'(in_ready), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst res_word", 64'(res_word), 64'd0);
    check("rst flags", 64'({cout, ovf, zero}), 64'd0);
    check("rst out_last", 64'(out_last), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step();
    check("rst start_ready", 64'(start_ready), 64'd1);

    // Add across a word boundary with carry into the upper word
    run_op("add2", 1'b0, 2'd1, 64'h0000_0000_0001_FFFF, 64'h0000_0000_0000_0001,
           64'h0000_0000_0002_0000, 1'b0, 1'b0, 1'b0);

    // Single-word subtract with signed overflow
    run_op("sub1", 1'b1, 2'd0, 64'h0000_0000_0000_8000, 64'h0000_0000_0000_0001,
           64'h0000_0000_0000_7FFF, 1'b1, 1'b1, 1'b0);

    // 64-bit subtract of equal operands
    run_op("sub4", 1'b1, 2'd3, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0,
           64'h0000_0000_0000_0000, 1'b1, 1'b0, 1'b1);

    // Backpressure in EMIT; a stray in_valid must not disturb the result
    do_start("bp", 1'b0, 2'd0);
    d0 = done_cnt;
    wait_in_ready("bp");
    a_word = 16'hFFFF;
    b_word = 16'h0001;
    in_valid = 1'b1;
    step();
    a_word = 16'h1111;
    b_word = 16'h2222;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp res_word[%0d]", i), 64'(res_word), 64'h0000);
      check($sformatf("bp in_ready[%0d]", i), 64'(in_ready), 64'd0);
      check($sformatf("bp out_valid[%0d]", i), 64'(out_valid), 64'd1);
      check($sformatf("bp out_last[%0d]", i), 64'(out_last), 64'd1);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp done", 64'(done), 64'd1);
    check("bp cout", 64'(cout), 64'd1);
    check("bp zero", 64'(zero), 64'd1);
    check("bp ovf", 64'(ovf), 64'd0);
    step();
    check("bp done_pulses", 64'(done_cnt - d0), 64'd1);

    // Reset during the third word of a 4-word add
    do_start("rstmid", 1'b0, 2'd3);
    d0 = done_cnt;
    for (int i = 0; i < 3; i++) begin
      wait_in_ready("rstmid");
      a_word = 16'hFFFF;
      b_word = 16'h0001;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      if (i < 2) begin
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
      end
    end
    check("rstmid out_valid_before", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid out_valid", 64'(out_valid), 64'd0);
    check("rstmid res_word", 64'(res_word), 64'd0);
    check("rstmid in_ready", 64'(in_ready), 64'd0);
    check("rstmid out_last", 64'(out_last), 64'd0);
    check("rstmid flags", 64'({cout, ovf, zero, done}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
    check("rstmid start_ready", 64'(start_ready), 64'd1);
    check("rstmid no_done", 64'(done_cnt - d0), 64'd0);
    run_op("post_rst", 1'b0, 2'd0, 64'h3, 64'h4, 64'h7, 1'b0, 1'b0, 1'b0);

`ifdef MPAS_ABORT_EN
    // Abort in IDLE has no effect
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("ab idle start_ready", 64'(start_ready), 64'd1);
    // Abort during EMIT of word 1 of a 32-bit subtract that overflows
    do_start("ab", 1'b1, 2'd1);
    d0 = done_cnt;
    wait_in_ready("ab");
    a_word = 16'h0000;
    b_word = 16'h0001;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("ab res0", 64'(res_word), 64'hFFFF);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    wait_in_ready("ab");
    a_word = 16'h8000;
    b_word = 16'h0000;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("ab res1", 64'(res_word), 64'h7FFF);
    check("ab ovf_set", 64'(ovf), 64'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("ab start_ready", 64'(start_ready), 64'd1);
    check("ab out_valid", 64'(out_valid), 64'd0);
    check("ab flags", 64'({cout, ovf, zero}), 64'd0);
    step();
    check("ab no_done", 64'(done_cnt - d0), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
